// File: rtl/block_mean_scheduler.sv
// Ping-pong frame buffer for gamma-fixed block means, streamed as header + data bytes to the LED link.
// Handshake: a byte moves when tx_valid & tx_ready at a rising edge; outputs are held while tx_valid & !tx_ready.
module block_mean_scheduler #(
  parameter int         BLK_H    = 16,
  parameter int         BLK_V    = 8,
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vs_i,
  input  logic [7:0] mean_i,
  input  logic       mean_valid_i,
  input  logic [5:0] block_v_i,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       tx_last,
  input  logic       tx_ready,
  output logic       busy,
  output logic [7:0] drop_cnt,
  output logic       sync_err,
  output logic [1:0] o_dbg_state
);
  localparam int         N     = BLK_H * BLK_V;
  localparam int         MW    = $clog2(2 * N);
  localparam logic [8:0] N9    = 9'(N);
  localparam logic [8:0] H9    = 9'(BLK_H);
  localparam logic [7:0] LAST8 = 8'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]    r_mem [0:2*N-1];
  logic          r_wbank;
  logic          r_vs;
  logic          r_frame_bad;
  logic          r_sync_err;
  logic [8:0]    r_wr_addr;
  logic [7:0]    r_rd_addr;
  logic [7:0]    r_drop_cnt;

  logic          w_vs_edge;
  logic          w_full;
  logic [8:0]    w_exp_row;
  logic          w_row_ok;
  logic          w_beat;
  logic          w_we;
  logic          w_err;
  logic [8:0]    w_addr_end;
  logic          w_complete;
  logic          w_swap;
  logic          w_last_addr;
  logic [MW-1:0] w_wr_idx;
  logic [MW-1:0] w_rd_idx;

  assign w_vs_edge  = vs_i & ~r_vs;
  assign w_full     = (r_wr_addr == N9);
  assign w_exp_row  = r_wr_addr / H9;
  assign w_row_ok   = ({3'b000, block_v_i} == w_exp_row);
  // Once a frame is marked bad its remaining beats are discarded silently.
  assign w_beat     = mean_valid_i & ~r_frame_bad;
  assign w_we       = w_beat & ~w_full & w_row_ok;
  assign w_err      = w_beat & (w_full | ~w_row_ok);
  assign w_addr_end = w_we ? (r_wr_addr + 9'd1) : r_wr_addr;
  assign w_complete = (w_addr_end == N9) & ~r_frame_bad & ~w_err;
  assign w_swap     = w_vs_edge & w_complete & (r_state == ST_IDLE);
  assign w_last_addr = (r_rd_addr == LAST8);

  // Bank W occupies the lower or upper half of r_mem; bank R is always the other half.
  assign w_wr_idx = r_wbank  ? (MW'(N) + MW'(r_wr_addr)) : MW'(r_wr_addr);
  assign w_rd_idx = ~r_wbank ? (MW'(N) + MW'(r_rd_addr)) : MW'(r_rd_addr);

  always_comb begin
    w_state_nxt = r_state;
    tx_valid    = 1'b0;
    tx_last     = 1'b0;
    tx_data     = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (w_swap) w_state_nxt = ST_HDR;
      end
      ST_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BYTE;
        if (tx_ready) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        tx_valid = 1'b1;
        tx_data  = r_mem[w_rd_idx];
        tx_last  = w_last_addr;
        if (tx_ready && w_last_addr) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs        <= 1'b0;
      r_wbank     <= 1'b0;
      r_wr_addr   <= 9'd0;
      r_rd_addr   <= 8'd0;
      r_frame_bad <= 1'b0;
      r_sync_err  <= 1'b0;
      r_drop_cnt  <= 8'd0;
    end else begin
      r_vs <= vs_i;
      if (w_err) r_sync_err <= 1'b1;
      // A beat landing on the vs edge cycle is already folded into w_complete.
      if (w_vs_edge) begin
        r_wr_addr   <= 9'd0;
        r_frame_bad <= 1'b0;
        if (w_swap) r_wbank <= ~r_wbank;
        else if (w_complete && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
      end else begin
        if (w_we)  r_wr_addr   <= r_wr_addr + 9'd1;
        if (w_err) r_frame_bad <= 1'b1;
      end
      if ((r_state == ST_HDR) && tx_ready) r_rd_addr <= 8'd0;
      else if ((r_state == ST_DATA) && tx_ready && !w_last_addr) r_rd_addr <= r_rd_addr + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we && !rst) r_mem[w_wr_idx] <= mean_i;
  end

  assign busy        = (r_state != ST_IDLE);
  assign drop_cnt    = r_drop_cnt;
  assign sync_err    = r_sync_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_block_mean_scheduler.sv
// Directed + randomized bench for block_mean_scheduler with a frame-level reference model.
module tb_block_mean_scheduler;
  localparam int BLK_H = 4;
  localparam int BLK_V = 2;
  localparam int N = BLK_H * BLK_V;
  localparam logic [7:0] HDR = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vs_i = 1'b0;
  logic [7:0] mean_i = 8'h00;
  logic       mean_valid_i = 1'b0;
  logic [5:0] block_v_i = 6'd0;
  logic       tx_ready = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       busy;
  logic [7:0] drop_cnt;
  logic       sync_err;
  logic [1:0] o_dbg_state;

  block_mean_scheduler #(.BLK_H(BLK_H), .BLK_V(BLK_V), .HDR_BYTE(HDR)) dut (
    .clk(clk), .rst(rst), .vs_i(vs_i), .mean_i(mean_i), .mean_valid_i(mean_valid_i),
    .block_v_i(block_v_i), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .busy(busy), .drop_cnt(drop_cnt), .sync_err(sync_err),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // scoreboard: {last, data} per byte
  logic [8:0] exp_q[$];
  logic [8:0] rx_q[$];
  int         rx_t[$];
  logic [7:0] frame_d[N];
  int         exp_drop = 0;
  logic       exp_sync = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // monitor: collects accepted bytes and checks stall stability
  logic       stall_p = 1'b0;
  logic [8:0] stall_v = 9'd0;
  always @(negedge clk) begin
    if (rst) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p) chk("hold", {tx_valid, tx_last, tx_data}, {1'b1, stall_v});
      if (tx_valid && tx_ready) begin
        rx_q.push_back({tx_last, tx_data});
        rx_t.push_back(cyc);
      end
      stall_p = tx_valid && !tx_ready;
      stall_v = {tx_last, tx_data};
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beats(input int nbeats, input int bad_idx, input bit seq, input bit vs_on_last);
    for (int i = 0; i < nbeats; i++) begin
      int row;
      logic [7:0] m;
      row = i / BLK_H;
      if (row > BLK_V - 1) row = BLK_V - 1;
      if (i == bad_idx) row = row ^ 1;
      m = seq ? 8'(i + 1) : 8'($urandom_range(0, 255));
      if (i < N) frame_d[i] = m;
      mean_i = m;
      block_v_i = 6'(row);
      mean_valid_i = 1'b1;
      if (vs_on_last && (i == nbeats - 1)) vs_i = 1'b1;
      step();
      mean_valid_i = 1'b0;
      vs_i = 1'b0;
      if (!(vs_on_last && (i == nbeats - 1)) && ($urandom_range(0, 3) == 0)) step();
    end
  endtask

  task automatic vs_pulse();
    vs_i = 1'b1;
    step();
    vs_i = 1'b0;
  endtask

  // reference model, evaluated right after the vs edge
  task automatic model_frame(input int nbeats, input int bad_idx);
    bit bad;
    bit complete;
    bad = (bad_idx >= 0) || (nbeats > N);
    complete = (nbeats == N) && (bad_idx < 0);
    if (bad) exp_sync = 1'b1;
    if (complete) begin
      if (exp_q.size() > rx_q.size()) begin
        if (exp_drop < 255) exp_drop++;
      end else begin
        exp_q.push_back({1'b0, HDR});
        for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), frame_d[i]});
      end
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_drop"}, drop_cnt, 8'(exp_drop));
    chk({tag, "_sync"}, sync_err, exp_sync);
  endtask

  task automatic drain(input int mode, input int budget, input bit gapless);
    int t;
    t = 0;
    while ((rx_q.size() < exp_q.size()) && (t < budget)) begin
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      step();
      t++;
    end
    tx_ready = 1'b1;
    repeat (4) step();
    tx_ready = 1'b0;
    chk("rx_count", rx_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < rx_q.size()) chk($sformatf("byte%0d", i), rx_q[i], exp_q[i]);
    if (gapless && (rx_t.size() == N + 1)) chk("gapless", rx_t[N] - rx_t[0], N);
    chk("idle_after", busy, 1'b0);
    rx_q.delete();
    rx_t.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // reset state
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_last", tx_last, 1'b0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drop", drop_cnt, 8'd0);
    chk("rst_sync", sync_err, 1'b0);
    chk("rst_state", o_dbg_state, 2'd0);

    // means 1..8, ready held high: header one cycle after swap, then no bubbles
    tx_ready = 1'b1;
    send_beats(N, -1, 1'b1, 1'b0);
    vs_pulse();
    model_frame(N, -1);
    chk("swap_valid", tx_valid, 1'b1);
    chk("swap_hdr", tx_data, HDR);
    chk("swap_busy", busy, 1'b1);
    drain(0, 40, 1'b1);
    chk_status("t1");

    // toggling ready
    tx_ready = 1'b0;
    send_beats(N, -1, 1'b0, 1'b0);
    vs_pulse();
    model_frame(N, -1);
    drain(1, 60, 1'b0);
    chk_status("t2");

    // second frame completes while first is stalled
    send_beats(N, -1, 1'b0, 1'b0);
    vs_pulse();
    model_frame(N, -1);
    send_beats(N, -1, 1'b0, 1'b0);
    vs_pulse();
    model_frame(N, -1);
    chk_status("t3");
    drain(2, 80, 1'b0);

    // row mismatch on beat 5, then a good frame
    send_beats(N, 4, 1'b0, 1'b0);
    vs_pulse();
    model_frame(N, 4);
    chk_status("t4a");
    drain(0, 20, 1'b0);
    send_beats(N, -1, 1'b0, 1'b0);
    vs_pulse();
    model_frame(N, -1);
    drain(2, 80, 1'b0);
    chk_status("t4b");

    // short and long frames
    send_beats(N - 1, -1, 1'b0, 1'b0);
    vs_pulse();
    model_frame(N - 1, -1);
    drain(0, 20, 1'b0);
    chk_status("t5a");
    send_beats(N + 1, -1, 1'b0, 1'b0);
    vs_pulse();
    model_frame(N + 1, -1);
    drain(0, 20, 1'b0);
    chk_status("t5b");

    // randomized frames, some with the last beat on the vs edge cycle
    for (int k = 0; k < 4; k++) begin
      int nb;
      nb = (k == 2) ? N + 1 : N;
      send_beats(nb, -1, 1'b0, 1'(k % 2));
      if (k % 2 == 0) vs_pulse();
      model_frame(nb, -1);
      drain(2, 80, 1'b0);
      chk_status($sformatf("rnd%0d", k));
    end

    // reset during DATA after three data bytes
    tx_ready = 1'b1;
    send_beats(N, -1, 1'b1, 1'b0);
    vs_pulse();
    model_frame(N, -1);
    t = 0;
    while ((rx_q.size() < 4) && (t < 40)) begin
      step();
      t++;
    end
    chk("mid_reached", rx_q.size(), 4);
    rst = 1'b1;
    step();
    chk("mid_valid", tx_valid, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_drop", drop_cnt, 8'd0);
    chk("mid_sync", sync_err, 1'b0);
    rst = 1'b0;
    rx_q.delete();
    rx_t.delete();
    exp_q.delete();
    exp_drop = 0;
    exp_sync = 1'b0;
    repeat (6) step();
    chk("post_rst_quiet", rx_q.size(), 0);
    send_beats(N, -1, 1'b0, 1'b0);
    vs_pulse();
    model_frame(N, -1);
    chk("post_rst_hdr", tx_data, HDR);
    drain(0, 40, 1'b1);
    chk_status("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/block_mean_scheduler.md
BLOCK_MEAN_SCHEDULER -- requirements
Module: block_mean_scheduler

Interface
REQ-001 SHALL have parameter BLK_H, default 16: block means per block row.
REQ-002 SHALL have parameter BLK_V, default 8: block rows per frame; BLK_H*BLK_V <= 256.
REQ-003 SHALL have parameter HDR_BYTE, default 8'hA5: start-of-frame byte sent before each frame's data.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 vs_i  input  1  frame sync, active-high, same timing as the block-mean datapath.
REQ-007 mean_i  input  8  gamma-fixed block mean.
REQ-008 mean_valid_i  input  1  mean_i qualifier, one-cycle pulse per block.
REQ-009 block_v_i  input  6  block row index of the current mean.
REQ-010 tx_data  output  8  byte to LED-driver link.
REQ-011 tx_valid  output  1  tx_data valid.
REQ-012 tx_last  output  1  marks final data byte of a frame.
REQ-013 tx_ready  input  1  downstream accepts the byte when tx_valid & tx_ready.
REQ-014 busy  output  1  readout FSM not IDLE.
REQ-015 drop_cnt  output  8  count of completed frames dropped, saturating at 255.
REQ-016 sync_err  output  1  sticky: a frame was aborted on row mismatch or count error.

Function
REQ-017 SHALL hold two banks of BLK_H*BLK_V bytes (ping-pong): write bank W and read bank R, W != R always.
REQ-018 SHALL write each mean_valid_i beat into W at address wr_addr, then increment wr_addr; expected row = wr_addr / BLK_H.
REQ-019 SHALL abort the frame on a beat with block_v_i != expected row: no write, set sync_err, frame_bad flag until next vs edge.
REQ-020 SHALL ignore beats once wr_addr = BLK_H*BLK_V (frame full); an extra beat sets sync_err and frame_bad.
REQ-021 SHALL detect vs rising edge as vs_i=1 with registered vs_i=0; act on it at the following clk edge.
REQ-022 At vs edge: frame complete = (wr_addr = BLK_H*BLK_V) & !frame_bad.
REQ-023 At vs edge, complete frame and FSM IDLE: swap W/R, FSM -> HDR.
REQ-024 At vs edge, complete frame and FSM not IDLE: no swap, drop_cnt +1 (saturating).
REQ-025 At vs edge, incomplete/bad frame: no swap, no drop_cnt change.
REQ-026 At every vs edge: wr_addr <= 0, frame_bad <= 0.
REQ-027 A mean_valid_i beat coinciding with the vs edge cycle SHALL belong to the ending frame.
REQ-028 FSM states: IDLE, HDR, DATA.
- IDLE: tx_valid=0.
- HDR: tx_data=HDR_BYTE, tx_valid=1; on accept -> DATA, rd_addr=0.
- DATA: tx_data=R[rd_addr], tx_valid=1; on accept rd_addr+1; accept at rd_addr=BLK_H*BLK_V-1 with tx_last=1 -> IDLE.
REQ-029 tx_data/tx_valid/tx_last SHALL be stable while tx_valid & !tx_ready; tx_valid SHALL not drop without acceptance.
REQ-030 tx_valid SHALL rise one cycle after the swap edge; with tx_ready held 1, a frame SHALL stream BLK_H*BLK_V+1 bytes on consecutive cycles, no bubbles.
REQ-031 Bank R SHALL never be written while FSM is not IDLE.
REQ-032 busy = (FSM != IDLE); tx_last=1 only in DATA at final address.

Reset
REQ-033 rst=1 SHALL force FSM IDLE, tx_valid=0, tx_last=0, tx_data=0, busy=0, drop_cnt=0, sync_err=0, wr_addr=0, rd_addr=0, frame_bad=0, W=bank0, R=bank1, vs register=0; bank contents not reset.
REQ-034 rst asserted mid-readout SHALL abort the frame; no further bytes after release until the next complete frame.

Verification
REQ-035 BLK_H=4,BLK_V=2: 8 beats of means 1..8 (correct rows), vs pulse, tx_ready=1 -> A5,01..08 on 9 consecutive cycles, tx_last on 08.
REQ-036 Same, tx_ready toggling 1/0 each cycle -> identical byte sequence, outputs held during stalls, 9 accepts.
REQ-037 Second complete frame ends while first still streaming (tx_ready=0) -> drop_cnt=1, first frame's bytes unchanged, no swap.
REQ-038 Beat 5 with block_v_i=0 (expected 1) -> sync_err=1, no readout at vs; next good frame streams normally.
REQ-039 7 beats then vs -> no readout, drop_cnt=0; 9 beats then vs -> sync_err=1, no readout.
REQ-040 rst pulse during DATA at byte 3 -> tx_valid=0 next cycle, all counters 0; next complete frame starts with A5.
